// File: rtl/rf_sequencer.sv
// rf_sequencer: Moore control FSM that steps the register-file datapath.
// Optional trap state on illegal codes: define RF_SEQ_ILLEGAL_TRAP_EN.
module rf_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       err
);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_DECODE,
    ST_WRITE_IMM,
    ST_GET_A,
    ST_GET_B,
    ST_ALU,
    ST_WRITE_REG,
    ST_TRAP
  } state_t;

  // ALU-cycle flavour, latched in DECODE so ALU outputs stay Moore
  typedef enum logic [1:0] {
    K_PASS,
    K_ARITH,
    K_CMP
  } kind_t;

  state_t state, next;
  kind_t  kind_q, dec_kind;
  state_t dec_next;
  logic [4:0] code;

  assign code = {opcode, op};

  // Decode the instruction class into a dispatch target and ALU flavour
  always_comb begin
    dec_kind = K_PASS;
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
    dec_next = ST_TRAP;
`else
    dec_next = ST_WAIT;
`endif
    case (code)
      5'b110_10: dec_next = ST_WRITE_IMM;
      5'b110_00: dec_next = ST_GET_B;
      5'b101_11: dec_next = ST_GET_B;
      5'b101_00: begin
        dec_next = ST_GET_A;
        dec_kind = K_ARITH;
      end
      5'b101_10: begin
        dec_next = ST_GET_A;
        dec_kind = K_ARITH;
      end
      5'b101_01: begin
        dec_next = ST_GET_A;
        dec_kind = K_CMP;
      end
      default: ;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) state <= ST_WAIT;
    else       state <= next;
  end

  // Capture the ALU flavour while the instruction is being decoded
  always_ff @(posedge clk) begin
    if (reset)                  kind_q <= K_PASS;
    else if (state == ST_DECODE) kind_q <= dec_kind;
  end

  // Next-state sequencing
  always_comb begin
    next = state;
    case (state)
      ST_WAIT:      if (s) next = ST_DECODE;
      ST_DECODE:    next = dec_next;
      ST_WRITE_IMM: next = ST_WAIT;
      ST_GET_A:     next = ST_GET_B;
      ST_GET_B:     next = ST_ALU;
      ST_ALU:       next = (kind_q == K_CMP) ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: next = ST_WAIT;
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
      ST_TRAP:      next = ST_TRAP;
`else
      ST_TRAP:      next = ST_WAIT;
`endif
      default:      next = ST_WAIT;
    endcase
  end

  // Moore output decode from registered state only
  always_comb begin
    w     = 1'b0;
    nsel  = 3'b000;
    vsel  = 2'b00;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    write = 1'b0;
    err   = 1'b0;
    case (state)
      ST_WAIT: w = 1'b1;
      ST_WRITE_IMM: begin
        nsel  = 3'b001;
        vsel  = 2'b01;
        write = 1'b1;
      end
      ST_GET_A: begin
        nsel  = 3'b001;
        loada = 1'b1;
      end
      ST_GET_B: begin
        nsel  = 3'b100;
        loadb = 1'b1;
      end
      ST_ALU: begin
        if (kind_q == K_CMP) begin
          loads = 1'b1;
        end else begin
          loadc = 1'b1;
          asel  = (kind_q == K_PASS);
        end
      end
      ST_WRITE_REG: begin
        nsel  = 3'b010;
        write = 1'b1;
      end
      ST_TRAP: begin
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
        err = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: randomized self-checking bench for rf_sequencer.
// Expected per-cycle outputs come from an instruction-level trace table.
module tb_rf_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada, loadb, loadc, loads;
  logic       asel, bsel, write, err;

  int n_chk = 0;
  int n_fail = 0;

  rf_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .opcode(opcode),
    .op    (op),
    .w     (w),
    .nsel  (nsel),
    .vsel  (vsel),
    .loada (loada),
    .loadb (loadb),
    .loadc (loadc),
    .loads (loads),
    .asel  (asel),
    .bsel  (bsel),
    .write (write),
    .err   (err)
  );

  always #5 clk = ~clk;

  // {w,err,nsel,vsel,loada,loadb,loadc,loads,asel,bsel,write}
  localparam logic [13:0] IDLE = 14'b1_0_000_00_0000000;
  localparam logic [13:0] DEC  = 14'b0_0_000_00_0000000;
  localparam logic [13:0] WIMM = 14'b0_0_001_01_0000001;
  localparam logic [13:0] GA   = 14'b0_0_001_00_1000000;
  localparam logic [13:0] GB   = 14'b0_0_100_00_0100000;
  localparam logic [13:0] ALUZ = 14'b0_0_000_00_0010100;
  localparam logic [13:0] ALUN = 14'b0_0_000_00_0010000;
  localparam logic [13:0] ALUC = 14'b0_0_000_00_0001000;
  localparam logic [13:0] WREG = 14'b0_0_010_00_0000001;
  localparam logic [13:0] TRP  = 14'b0_1_000_00_0000000;

  localparam int TRAP_HOLD = 20;

  logic [13:0] exp_q[$];

  function automatic logic [13:0] obs();
    return {w, err, nsel, vsel, loada, loadb, loadc, loads,
            asel, bsel, write};
  endfunction

  // 0 illegal, 1 mov imm, 2 mov reg/mvn, 3 add/and, 4 cmp
  function automatic int classify(input logic [2:0] oc,
                                  input logic [1:0] o);
    case ({oc, o})
      5'b110_10: return 1;
      5'b110_00: return 2;
      5'b101_11: return 2;
      5'b101_00: return 3;
      5'b101_10: return 3;
      5'b101_01: return 4;
      default:   return 0;
    endcase
  endfunction

  // Per-cycle expectation starting with the cycle after s is sampled
  task automatic build_trace(input logic [2:0] oc, input logic [1:0] o);
    exp_q.delete();
    exp_q.push_back(DEC);
    case (classify(oc, o))
      1: exp_q.push_back(WIMM);
      2: begin
        exp_q.push_back(GB);
        exp_q.push_back(ALUZ);
        exp_q.push_back(WREG);
      end
      3: begin
        exp_q.push_back(GA);
        exp_q.push_back(GB);
        exp_q.push_back(ALUN);
        exp_q.push_back(WREG);
      end
      4: begin
        exp_q.push_back(GA);
        exp_q.push_back(GB);
        exp_q.push_back(ALUC);
      end
      default: begin
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
        for (int k = 0; k < TRAP_HOLD; k++) exp_q.push_back(TRP);
`endif
      end
    endcase
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
    if (classify(oc, o) != 0) exp_q.push_back(IDLE);
`else
    exp_q.push_back(IDLE);
`endif
  endtask

  task automatic run_instr(input string nm, input logic [2:0] oc,
                           input logic [1:0] o);
    logic [13:0] got;
    build_trace(oc, o);
    opcode = oc;
    op     = o;
    s      = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      got = obs();
      n_chk++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cyc%0d code=%b_%b got=%b exp=%b",
                 nm, i + 1, oc, o, got, exp_q[i]);
      end
      s = (exp_q[i] == IDLE) ? 1'b0 : 1'($urandom);
    end
    if (exp_q[exp_q.size() - 1] == TRP) begin
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      s = 1'b0;
      got = obs();
      n_chk++;
      if (got !== IDLE) begin
        n_fail++;
        $display("FAIL %s trap_clear got=%b exp=%b", nm, got, IDLE);
      end
    end
  endtask

  task automatic test_reset();
    logic [13:0] got;
    reset  = 1'b1;
    s      = 1'b1;
    opcode = 3'b110;
    op     = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    got = obs();
    n_chk++;
    if (got !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state got=%b exp=%b", got, IDLE);
    end
    reset = 1'b0;
    s     = 1'b0;
  endtask

  task automatic test_directed();
    run_instr("mov_imm", 3'b110, 2'b10);
    run_instr("mov_reg", 3'b110, 2'b00);
    run_instr("mvn",     3'b101, 2'b11);
    run_instr("add",     3'b101, 2'b00);
    run_instr("cmp",     3'b101, 2'b01);
    run_instr("and",     3'b101, 2'b10);
  endtask

  task automatic test_illegal();
    run_instr("illegal_000", 3'b000, 2'b00);
    run_instr("illegal_110_01", 3'b110, 2'b01);
    run_instr("illegal_111_11", 3'b111, 2'b11);
  endtask

  task automatic test_reset_mid();
    logic [13:0] got;
    opcode = 3'b101;
    op     = 2'b00;
    s      = 1'b1;
    @(posedge clk);
    #1;
    s = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    got = obs();
    n_chk++;
    if (got !== GB) begin
      n_fail++;
      $display("FAIL reset_mid_getb got=%b exp=%b", got, GB);
    end
    reset = 1'b1;
    s     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    s     = 1'b0;
    got = obs();
    n_chk++;
    if (got !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_abort got=%b exp=%b", got, IDLE);
    end
    @(posedge clk);
    #1;
    got = obs();
    n_chk++;
    if (got !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_after got=%b exp=%b", got, IDLE);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] got;
    logic [13:0] pat[3];
    pat[0] = DEC;
    pat[1] = WIMM;
    pat[2] = IDLE;
    opcode = 3'b110;
    op     = 2'b10;
    s      = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      got = obs();
      n_chk++;
      if (got !== pat[i % 3]) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d got=%b exp=%b",
                 i + 1, got, pat[i % 3]);
      end
    end
    s = 1'b0;
    @(posedge clk);
    #1;
    got = obs();
    n_chk++;
    if (got !== IDLE) begin
      n_fail++;
      $display("FAIL back_to_back_idle got=%b exp=%b", got, IDLE);
    end
  endtask

  task automatic test_random();
    logic [2:0] oc;
    logic [1:0] o;
    for (int n = 0; n < 40; n++) begin
      oc = 3'($urandom_range(0, 7));
      o  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) oc = ($urandom_range(0, 3) == 0)
                                          ? 3'b110 : 3'b101;
      run_instr("random", oc, o);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    s      = 1'b0;
    opcode = 3'b000;
    op     = 2'b00;
    @(negedge clk);
    test_reset();
    test_directed();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_sequencer.md
RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` (all state updates on its rising edge) and `reset`.
REQ-002 Port `clk`  in  1  rising-edge clock.
REQ-003 Port `reset`  in  1  synchronous active-high reset.
REQ-004 Port `s`  in  1  start request, sampled only in WAIT.
REQ-005 Port `opcode`  in  3  instruction class, held stable by the instruction register from `s` until `w` returns high.
REQ-006 Port `op`  in  2  sub-operation, with the same stability rule as `opcode`.
REQ-007 Port `w`  out  1  idle/ready, high only in WAIT.
REQ-008 Port `nsel`  out  3  register-file index select, one-hot: 001 Rn, 010 Rd, 100 Rm, 000 none.
REQ-009 Port `vsel`  out  2  write-data select: 00 ALU result C, 01 sign-extended imm8; 10 and 11 are never driven.
REQ-010 Ports `loada`, `loadb`, `loadc`, `loads`  out  1 each  load enables for operand registers A and B, result register C and the status register.
REQ-011 Ports `asel`, `bsel`  out  1 each  asel=1 forces ALU operand A to zero; bsel is always 0.
REQ-012 Port `write`  out  1  register-file write enable.
REQ-013 Port `err`  out  1  illegal-instruction flag; see REQ-028.

Function
REQ-014 The FSM SHALL have the states WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG and TRAP.
REQ-015 All outputs SHALL be Moore outputs decoded from the state register only; there SHALL be no combinational path from inputs to outputs.
REQ-016 Any output not listed for the current state SHALL be 0.
REQ-017 WAIT: `w`=1; `s`=1 at a clock edge -> DECODE; otherwise stay in WAIT.
REQ-018 Outside WAIT, `s` SHALL be ignored.
REQ-019 DECODE: no outputs asserted; next state from {opcode,op}:
- 110,10 MOV imm -> WRITE_IMM
- 110,00 MOV reg -> GET_B
- 101,11 MVN -> GET_B
- 101,00 ADD / 101,01 CMP / 101,10 AND -> GET_A
- any other code -> illegal (REQ-028).
REQ-020 WRITE_IMM: `nsel`=001, `vsel`=01, `write`=1; next state WAIT.
REQ-021 GET_A: `nsel`=001, `loada`=1; next state GET_B.
REQ-022 GET_B: `nsel`=100, `loadb`=1; next state ALU.
REQ-023 ALU for MOV reg and MVN: `asel`=1, `loadc`=1; next state WRITE_REG.
REQ-024 ALU for ADD and AND: `asel`=0, `loadc`=1; next state WRITE_REG.
REQ-025 ALU for CMP: `loads`=1, `loadc`=0; next state WAIT, with no register-file write.
REQ-026 WRITE_REG: `nsel`=010, `vsel`=00, `write`=1; next state WAIT.
REQ-027 Latency from the edge sampling `s` to `w` high SHALL be:
- MOV imm: 3 cycles
- MOV reg and MVN: 5 cycles
- CMP: 5 cycles
- ADD and AND: 6 cycles.
REQ-028 Illegal code in DECODE: behaviour is set by REQ-034 and REQ-035; in either case no load or write strobe is ever asserted for that instruction.
REQ-029 Back-to-back operation: with `s` held high, the block SHALL enter DECODE on the edge after it arrives in WAIT, giving exactly one WAIT cycle between instructions.
REQ-030 `write` SHALL be asserted for exactly one cycle per writing instruction, and never together with `loada`, `loadb`, `loadc` or `loads`.

Reset
REQ-031 `reset`=1 at a rising edge SHALL force WAIT from any state, including TRAP, and SHALL take priority over `s`.
REQ-032 After reset: `w`=1, `err`=0, and all other outputs 0.
REQ-033 Reset mid-instruction SHALL abort it; no `write` or load strobe is produced in the cycle after the reset edge.

Configuration
REQ-034 With macro RF_SEQ_ILLEGAL_TRAP_EN defined, an illegal code in DECODE SHALL go to TRAP. In TRAP: `err`=1, `w`=0, all strobes 0, and the block stays there until reset.
REQ-035 Without RF_SEQ_ILLEGAL_TRAP_EN, an illegal code in DECODE SHALL go to WAIT (2-cycle latency); TRAP is unreachable and `err` is tied to 0.

Verification
REQ-036 Reset then MOV imm: reset for 1 edge, then s=1 with opcode=110, op=10 -> WRITE_IMM cycle shows nsel=001, vsel=01, write=1; w high 3 cycles after s is sampled.
REQ-037 ADD: opcode=101, op=00 -> strobe sequence loada(nsel=001), loadb(nsel=100), loadc(asel=0), write(nsel=010, vsel=00); w high at cycle 6.
REQ-038 CMP: opcode=101, op=01 -> loads=1 in ALU, write never asserted, w high at cycle 5; MVN: opcode=101, op=11 -> asel=1 in ALU, write in cycle 4.
REQ-039 Illegal opcode=000 -> with macro: err=1 and w=0 held for 20 cycles, then reset clears both; without macro: w=1 at cycle 2 and no strobes at any point.
REQ-040 Reset asserted in GET_B of an ADD -> WAIT on the next edge, write never asserted; s held high continuously -> exactly one WAIT cycle between consecutive MOV imm instructions.
